apb_ram_ws: RTL and testbench

Parametrised APB3 slave RAM for the RISC-V APB peripheral bus. It generalises the fixed 32-bit, zero-configuration RAM slave with configurable data width, depth and inserted wait states. It adds PSLVERR reporting for out-of-range addresses. It sits behind the APB decoder as a memory-mapped scratch/data RAM.

---
 rtl/apb_ram_ws.sv | 119 +++++++++++
 tb/tb_apb_ram_ws.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_ram_ws.sv
// apb_ram_ws: APB3 slave RAM with configurable width, depth and wait states, with PSLVERR for out-of-range addresses.
// Define APB_RAM_PSTRB_EN to add the PSTRB port and per-byte write enables.
module apb_ram_ws #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned WAIT_CYC = 0,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [ADDR_W-1:0]     PADDR,
    input  logic                  PWRITE,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [DATA_W-1:0]     PWDATA,
`ifdef APB_RAM_PSTRB_EN
    input  logic [DATA_W/8-1:0]   PSTRB,
`endif
    output logic [DATA_W-1:0]     PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned BO    = $clog2(NB);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic               commit;
    logic               access;
    logic               in_range;
    logic [IDX_W-1:0]   idx;
    logic [NB-1:0]      wr_be;
    logic               mem_we;

    logic [DATA_W-1:0]  mem [DEPTH];

    assign access   = PSEL & PENABLE;
    assign idx      = PADDR[BO+IDX_W-1:BO];
    // Range limit is DEPTH*NB bytes, a power of two, so any set bit above the index field is out of range.
    assign in_range = (PADDR >> (BO + IDX_W)) == '0;
    assign mem_we   = commit & PWRITE & in_range;

`ifdef APB_RAM_PSTRB_EN
    assign wr_be = PSTRB;
`else
    assign wr_be = '1;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        commit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (access) begin
                    cnt_n   = CNT_W'(WAIT_CYC);
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!access) begin
                    state_n = S_IDLE;
                end else if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    commit  = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state   <= S_IDLE;
            cnt     <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            PREADY  <= commit;
            PSLVERR <= commit & ~in_range;
            if (commit && !PWRITE) begin
                PRDATA <= in_range ? mem[idx] : '0;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge PCLK) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[idx][i*8 +: 8] <= PWDATA[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_ram_ws.sv
// tb_apb_ram_ws: scoreboard bench for apb_ram_ws with two instances (WAIT_CYC=0 and WAIT_CYC=3).
// Directed transfers push expected responses; a monitor pops and checks them on each PREADY.
module tb_apb_ram_ws;

    localparam int unsigned W0 = 0;
    localparam int unsigned W1 = 3;

    logic        pclk    = 1'b0;
    logic        preset  = 1'b1;
    logic [31:0] paddr   = '0;
    logic        pwrite  = 1'b0;
    logic        penable = 1'b0;
    logic [31:0] pwdata  = '0;
    logic        psel0   = 1'b0;
    logic        psel1   = 1'b0;
`ifdef APB_RAM_PSTRB_EN
    logic [3:0]  pstrb   = 4'hF;
`endif
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_rd [2];

    typedef struct {
        int unsigned dut;
        logic        slverr;
        logic [31:0] rdata;
        string       name;
    } exp_t;

    exp_t        sb_q [$];
    int unsigned acc_cnt [2];
    logic        prev_rdy [2];

    always #5 pclk = ~pclk;

    apb_ram_ws #(.DATA_W(32), .DEPTH(1024), .WAIT_CYC(W0), .ADDR_W(32)) u_dut0 (
        .PCLK(pclk), .PRESET(preset), .PADDR(paddr), .PWRITE(pwrite), .PSEL(psel0),
        .PENABLE(penable), .PWDATA(pwdata),
`ifdef APB_RAM_PSTRB_EN
        .PSTRB(pstrb),
`endif
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
    );

    apb_ram_ws #(.DATA_W(32), .DEPTH(1024), .WAIT_CYC(W1), .ADDR_W(32)) u_dut1 (
        .PCLK(pclk), .PRESET(preset), .PADDR(paddr), .PWRITE(pwrite), .PSEL(psel1),
        .PENABLE(penable), .PWDATA(pwdata),
`ifdef APB_RAM_PSTRB_EN
        .PSTRB(pstrb),
`endif
        .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1)
    );

    function automatic logic rdy_of(input int unsigned d);
        return (d == 0) ? pready0 : pready1;
    endfunction

    function automatic logic err_of(input int unsigned d);
        return (d == 0) ? pslverr0 : pslverr1;
    endfunction

    function automatic logic [31:0] rdata_of(input int unsigned d);
        return (d == 0) ? prdata0 : prdata1;
    endfunction

    function automatic logic sel_of(input int unsigned d);
        return (d == 0) ? psel0 : psel1;
    endfunction

    function automatic int unsigned wait_of(input int unsigned d);
        return (d == 0) ? W0 : W1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic set_sel(input int unsigned d, input logic v);
        if (d == 0) psel0 = v;
        else        psel1 = v;
    endtask

    // Monitor: counts sampled access edges per instance and checks each PREADY against the scoreboard.
    initial begin
        exp_t e;
        logic r;
        acc_cnt[0]  = 0;
        acc_cnt[1]  = 0;
        prev_rdy[0] = 1'b0;
        prev_rdy[1] = 1'b0;
        forever begin
            @(posedge pclk);
            for (int unsigned i = 0; i < 2; i++) begin
                acc_cnt[i] = (penable && sel_of(i) && !preset) ? acc_cnt[i] + 1 : 0;
            end
            #1;
            for (int unsigned i = 0; i < 2; i++) begin
                r = rdy_of(i);
                if (preset) begin
                    prev_rdy[i] = 1'b0;
                end else if (prev_rdy[i]) begin
                    check($sformatf("ready_one_cycle_dut%0d", i), 32'(r), 32'd0);
                    prev_rdy[i] = r;
                end else if (r) begin
                    prev_rdy[i] = 1'b1;
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_pready_dut%0d: got PREADY=1, required no response", i);
                    end else begin
                        e = sb_q.pop_front();
                        check({e.name, "_dut"},     32'(i),          32'(e.dut));
                        check({e.name, "_pslverr"}, 32'(err_of(i)),  32'(e.slverr));
                        check({e.name, "_prdata"},  rdata_of(i),     e.rdata);
                        check({e.name, "_latency"}, acc_cnt[i],      wait_of(i) + 2);
                    end
                end
            end
        end
    end

    task automatic apb(input int unsigned d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb, input logic err,
                       input logic [31:0] rd, input string name);
        exp_t e;
        logic got;
        e.dut    = d;
        e.slverr = err;
        e.rdata  = wr ? last_rd[d] : rd;
        e.name   = name;
        if (!wr) last_rd[d] = rd;
        sb_q.push_back(e);
        @(negedge pclk);
        paddr  = addr;
        pwrite = wr;
        pwdata = wdata;
`ifdef APB_RAM_PSTRB_EN
        pstrb  = strb;
`else
        if (strb != 4'hF) $display("[TB] %s: strobes ignored without APB_RAM_PSTRB_EN", name);
`endif
        set_sel(d, 1'b1);
        @(negedge pclk);
        penable = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge pclk);
            #2;
            got = rdy_of(d);
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no PREADY in 40 cycles, required PREADY=1", name);
            sb_q.delete(sb_q.size() - 1);
        end
        @(negedge pclk);
        set_sel(d, 1'b0);
        penable = 1'b0;
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got no completion by time limit, required $finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        last_rd[0] = '0;
        last_rd[1] = '0;

        #12;
        check("rst_pready0",  32'(pready0),  32'd0);
        check("rst_pslverr0", 32'(pslverr0), 32'd0);
        check("rst_prdata0",  prdata0,       32'd0);
        check("rst_pready1",  32'(pready1),  32'd0);
        check("rst_prdata1",  prdata1,       32'd0);
        @(negedge pclk);
        preset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge pclk);
            #2;
            check($sformatf("idle_ready_c%0d", c), 32'({pready1, pready0}), 32'd0);
        end

        // Zero-wait instance: basic, out-of-range and boundary accesses.
        apb(0, 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 4'hF, 1'b0, '0,            "w_000");
        apb(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, '0,            "w_010");
        apb(0, 1'b0, 32'h0000_0010, '0,            4'hF, 1'b0, 32'hDEAD_BEEF, "r_010");
        apb(0, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 1'b1, '0,            "w_1000_oor");
        apb(0, 1'b1, 32'h0000_1010, 32'h0BAD_BEEF, 4'hF, 1'b1, '0,            "w_1010_oor");
        apb(0, 1'b0, 32'h0000_0000, '0,            4'hF, 1'b0, 32'hA5A5_A5A5, "r_000");
        apb(0, 1'b0, 32'h0000_0010, '0,            4'hF, 1'b0, 32'hDEAD_BEEF, "r_010_noalias");
        apb(0, 1'b0, 32'h0000_1000, '0,            4'hF, 1'b1, 32'h0,         "r_1000_oor");
        apb(0, 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 4'hF, 1'b0, '0,            "w_0ffc");
        apb(0, 1'b0, 32'h0000_0FFC, '0,            4'hF, 1'b0, 32'hCAFE_F00D, "r_0ffc");
        apb(0, 1'b0, 32'h0000_0FFF, '0,            4'hF, 1'b0, 32'hCAFE_F00D, "r_0fff");
        apb(0, 1'b0, 32'h0000_0013, '0,            4'hF, 1'b0, 32'hDEAD_BEEF, "r_013");
        apb(0, 1'b0, 32'h8000_0010, '0,            4'hF, 1'b1, 32'h0,         "r_high_oor");
`ifdef APB_RAM_PSTRB_EN
        apb(0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 1'b0, '0,            "w_020_full");
        apb(0, 1'b1, 32'h0000_0020, 32'h00AA_0000, 4'h4, 1'b0, '0,            "w_020_lane2");
        apb(0, 1'b0, 32'h0000_0020, '0,            4'hF, 1'b0, 32'hFFAA_FFFF, "r_020_lane2");
        apb(0, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'h0, 1'b0, '0,            "w_020_nostrb");
        apb(0, 1'b0, 32'h0000_0020, '0,            4'hF, 1'b0, 32'hFFAA_FFFF, "r_020_nostrb");
`else
        apb(0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 1'b0, '0,            "w_020_full");
        apb(0, 1'b1, 32'h0000_0020, 32'h00AA_0000, 4'hF, 1'b0, '0,            "w_020_word");
        apb(0, 1'b0, 32'h0000_0020, '0,            4'hF, 1'b0, 32'h00AA_0000, "r_020_word");
`endif

        // Three-wait instance: latency, aborted transfer.
        apb(1, 1'b1, 32'h0000_0004, 32'h1357_9BDF, 4'hF, 1'b0, '0,            "w_004_ws3");
        apb(1, 1'b0, 32'h0000_0004, '0,            4'hF, 1'b0, 32'h1357_9BDF, "r_004_ws3");
        @(negedge pclk);
        paddr  = 32'h0000_0004;
        pwrite = 1'b1;
        pwdata = 32'hFFFF_0000;
        psel1  = 1'b1;
        @(negedge pclk);
        penable = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        psel1   = 1'b0;
        penable = 1'b0;
        repeat (8) @(posedge pclk);
        #2;
        check("abort_no_ready", 32'(pready1), 32'd0);
        apb(1, 1'b0, 32'h0000_0004, '0,            4'hF, 1'b0, 32'h1357_9BDF, "r_004_after_abort");

        // Reset during the wait states of a write: the write is lost.
        apb(1, 1'b1, 32'h0000_0008, 32'h1111_1111, 4'hF, 1'b0, '0,            "w_008_pre");
        @(negedge pclk);
        paddr  = 32'h0000_0008;
        pwrite = 1'b1;
        pwdata = 32'h2222_2222;
        psel1  = 1'b1;
        @(negedge pclk);
        penable = 1'b1;
        @(posedge pclk);
        @(posedge pclk);
        #3 preset = 1'b1;
        #1;
        check("rst_mid_pready1", 32'(pready1), 32'd0);
        check("rst_mid_prdata1", prdata1,      32'd0);
        @(negedge pclk);
        preset  = 1'b0;
        psel1   = 1'b0;
        penable = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;

        // Reset while PREADY is high: outputs clear before the next edge.
        e.dut = 0; e.slverr = 1'b0; e.rdata = 32'hDEAD_BEEF; e.name = "r_010_done_rst";
        sb_q.push_back(e);
        @(negedge pclk);
        paddr  = 32'h0000_0010;
        pwrite = 1'b0;
        psel0  = 1'b1;
        @(negedge pclk);
        penable = 1'b1;
        @(posedge pclk);
        @(posedge pclk);
        #3 preset = 1'b1;
        #1;
        check("rst_done_pready0",  32'(pready0),  32'd0);
        check("rst_done_pslverr0", 32'(pslverr0), 32'd0);
        check("rst_done_prdata0",  prdata0,       32'd0);
        @(negedge pclk);
        preset  = 1'b0;
        psel0   = 1'b0;
        penable = 1'b0;

        apb(1, 1'b0, 32'h0000_0008, '0,            4'hF, 1'b0, 32'h1111_1111, "r_008_post_rst");
        apb(0, 1'b1, 32'h0000_0100, 32'h5555_AAAA, 4'hF, 1'b0, '0,            "w_100_post_rst");
        apb(0, 1'b0, 32'h0000_0010, '0,            4'hF, 1'b0, 32'hDEAD_BEEF, "r_010_post_rst");

        repeat (4) @(posedge pclk);
        #2;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
